clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_ctrl.sv | 102 ++++++++++
 tb/tb_clock_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// Time-of-day clock with RUN / SET_HR / SET_MIN editing and blink blanking.
// Seconds carry into minutes and hours only while running.
module clock_ctrl #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       blink_2hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       hour_pulse
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    BAD     = 2'd3
  } state_t;

  localparam logic [4:0] HMAX = 5'(HOUR_MAX);

  state_t     state, state_d;
  logic [4:0] hour_d;
  logic [5:0] min_d, sec_d;
  logic       hp_d;

  // Out-of-range values fold back to zero on the next increment.
  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hr(input logic [4:0] v);
    return (v >= HMAX) ? 5'd0 : v + 5'd1;
  endfunction

  always_comb begin
    state_d = state;
    hour_d  = hour;
    min_d   = min;
    sec_d   = sec;
    hp_d    = 1'b0;
    unique case (state)
      RUN: begin
        if (tick_1hz) begin
          sec_d = inc60(sec);
          if (sec >= 6'd59) begin
            min_d = inc60(min);
            if (min >= 6'd59) begin
              hour_d = inc_hr(hour);
              hp_d   = 1'b1;
            end
          end
        end
        if (key_mode) state_d = SET_HR;
      end
      SET_HR: begin
        if (key_mode)     state_d = SET_MIN;
        else if (key_inc) hour_d  = inc_hr(hour);
      end
      SET_MIN: begin
        if (key_mode) begin
          state_d = RUN;
          sec_d   = 6'd0;
        end else if (key_inc) begin
          min_d = inc60(min);
        end
      end
      BAD: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      hour       <= 5'd0;
      min        <= 6'd0;
      sec        <= 6'd0;
      hour_pulse <= 1'b0;
      blank_hr   <= 1'b0;
      blank_min  <= 1'b0;
    end else begin
      state      <= state_d;
      hour       <= hour_d;
      min        <= min_d;
      sec        <= sec_d;
      hour_pulse <= hp_d;
      blank_hr   <= (state_d == SET_HR) && !blink_2hz;
      blank_min  <= (state_d == SET_MIN) && !blink_2hz;
    end
  end

  assign mode = (state == BAD) ? 2'd0 : state;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed-vector bench for clock_ctrl (HOUR_MAX = 23).
// Table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, blink_2hz, key_mode, key_inc;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic [1:0] mode;
  logic       blank_hr, blank_min, hour_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  clock_ctrl #(.HOUR_MAX(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .tick_1hz(tick_1hz), .blink_2hz(blink_2hz),
    .key_mode(key_mode), .key_inc(key_inc),
    .hour(hour), .min(min), .sec(sec), .mode(mode),
    .blank_hr(blank_hr), .blank_min(blank_min),
    .hour_pulse(hour_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       t, m, i, b;
    logic [4:0] h;
    logic [5:0] mi, s;
    logic [1:0] md;
    logic       bh, bm, hp;
  } vec_t;

  vec_t vt [11];

  function automatic logic [31:0] pk(
    input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s,
    input logic [1:0] md, input logic bh, input logic bm, input logic hp);
    return {10'd0, h, mi, s, md, bh, bm, hp};
  endfunction

  function automatic logic [31:0] obs();
    return pk(hour, min, sec, mode, blank_hr, blank_min, hour_pulse);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic m, input logic i,
                     input logic b);
    tick_1hz  = t;
    key_mode  = m;
    key_inc   = i;
    blink_2hz = b;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  int hp_seen;
  int pulses;
  int mode_bad;

  initial begin
    rst_n     = 1'b0;
    tick_1hz  = 1'b0;
    key_mode  = 1'b0;
    key_inc   = 1'b0;
    blink_2hz = 1'b1;
    #3;
    chk("reset_async", obs(), pk(0, 0, 0, 0, 0, 0, 0));

    //        t  m  i  b   h  min sec md bh bm hp
    vt[0]  = '{1, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 1,  0, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{1, 1, 0, 1,  0, 0, 2, 1, 0, 0, 0};
    vt[3]  = '{0, 0, 1, 0,  1, 0, 2, 1, 1, 0, 0};
    vt[4]  = '{1, 0, 0, 0,  1, 0, 2, 1, 1, 0, 0};
    vt[5]  = '{0, 0, 1, 1,  2, 0, 2, 1, 0, 0, 0};
    vt[6]  = '{0, 1, 1, 0,  2, 0, 2, 2, 0, 1, 0};
    vt[7]  = '{0, 0, 1, 0,  2, 1, 2, 2, 0, 1, 0};
    vt[8]  = '{1, 0, 0, 1,  2, 1, 2, 2, 0, 0, 0};
    vt[9]  = '{1, 1, 0, 0,  2, 1, 0, 0, 0, 0, 0};
    vt[10] = '{1, 0, 0, 0,  2, 1, 1, 0, 0, 0, 0};

    do_reset();
    for (int v = 0; v < 11; v++) begin
      cyc(vt[v].t, vt[v].m, vt[v].i, vt[v].b);
      chk($sformatf("vec%0d", v), obs(),
          pk(vt[v].h, vt[v].mi, vt[v].s, vt[v].md,
             vt[v].bh, vt[v].bm, vt[v].hp));
    end

    // Set sequence from 00:00:17 ending at 05:01:00
    do_reset();
    for (int k = 0; k < 17; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("set_start", obs(), pk(0, 0, 17, 0, 0, 0, 0));
    hp_seen = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("set_mode1", 32'(mode), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      hp_seen += int'(hour_pulse);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("set_hr_frozen", obs(), pk(5, 0, 17, 1, 0, 0, 0));
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("set_mode2", 32'(mode), 32'd2);
    for (int k = 0; k < 61; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      hp_seen += int'(hour_pulse);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("set_min_frozen", obs(), pk(5, 1, 17, 2, 0, 0, 0));
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("set_end", obs(), pk(5, 1, 0, 0, 0, 0, 0));
    chk("set_no_pulse", 32'(hp_seen), 32'd0);

    // Blink roles in SET_HR then SET_MIN
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("blink_hr_lo", {30'd0, blank_hr, blank_min}, 32'b10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("blink_hr_hi", {30'd0, blank_hr, blank_min}, 32'b00);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("blink_min_lo", {30'd0, blank_hr, blank_min}, 32'b01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("blink_min_hi", {30'd0, blank_hr, blank_min}, 32'b00);

    // Rollover at 23:59:59
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    incs(23);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    incs(59);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 59; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("roll_pre", obs(), pk(23, 59, 59, 0, 0, 0, 0));
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("roll_wrap", obs(), pk(0, 0, 0, 0, 0, 0, 1));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("roll_pulse_end", obs(), pk(0, 0, 0, 0, 0, 0, 0));

    // Hour wrap in SET_HR, then async reset mid SET_MIN at 07:33:00
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    incs(24);
    chk("set_hr_wrap", 32'(hour), 32'd0);
    incs(7);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    incs(33);
    chk("pre_async", obs(), pk(7, 33, 0, 2, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", obs(), pk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("post_reset_tick", obs(), pk(0, 0, 1, 0, 0, 0, 0));

    // Free run for one full day
    do_reset();
    pulses   = 0;
    mode_bad = 0;
    tick_1hz = 1'b1;
    for (int k = 0; k < 86400; k++) begin
      @(posedge clk);
      #1;
      pulses += int'(hour_pulse);
      if (mode != 2'd0) mode_bad++;
      if (k == 3599)
        chk("day_1h", obs(), pk(1, 0, 0, 0, 0, 0, 1));
    end
    tick_1hz = 1'b0;
    chk("day_end", obs(), pk(0, 0, 0, 0, 0, 0, 1));
    chk("day_pulses", 32'(pulses), 32'd24);
    chk("day_mode", 32'(mode_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
